// File: rtl/axi_lite_dmem.sv
// AXI4-Lite slave data memory: word-aligned reads and byte-strobed writes
// into a single-port synchronous RAM. Addresses outside the window get SLVERR.
// The read and write channels have separate FSMs. A write commit owns the
// RAM port for its cycle, and a read that wants the port then waits one cycle.
module axi_lite_dmem #(
  parameter int          WORDS_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [2:0]  axi_arprot,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [2:0]  axi_awprot,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);

  localparam int DEPTH = 1 << WORDS_LOG2;

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_READ   = 2'd1;
  localparam logic [1:0] R_RESP   = 2'd2;

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_COMMIT = 2'd1;
  localparam logic [1:0] W_RESP   = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // True when the byte address falls inside this memory's window.
  function automatic logic in_window(input logic [31:0] addr);
    return addr[31:WORDS_LOG2+2] == BASE_ADDR[31:WORDS_LOG2+2];
  endfunction

  logic [31:0] mem [DEPTH];

  logic [1:0]  r_state;
  logic [31:0] raddr;
  logic [1:0]  w_state;
  logic [31:0] waddr;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_got;
  logic        w_got;

  logic [WORDS_LOG2-1:0] ridx;
  logic [WORDS_LOG2-1:0] widx;
  logic                  r_hit;
  logic                  w_hit;
  logic                  commit;
  logic                  we;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  aw_next;
  logic                  w_next;

  assign ridx    = raddr[WORDS_LOG2+1:2];
  assign widx    = waddr[WORDS_LOG2+1:2];
  assign r_hit   = in_window(raddr);
  assign w_hit   = in_window(waddr);
  assign commit  = (w_state == W_COMMIT);
  // A reset arriving on the commit edge abandons the write before it lands.
  assign we      = commit && w_hit && rstn;
  assign aw_hs   = axi_awvalid && axi_awready;
  assign w_hs    = axi_wvalid && axi_wready;
  assign aw_next = aw_got || aw_hs;
  assign w_next  = w_got || w_hs;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{axi_arprot, axi_awprot, raddr[1:0], waddr[1:0]};

  // RAM write port: byte-lane update of the committed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // Read channel FSM; the RAM read is registered straight into rdata.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= R_IDLE;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (axi_arvalid && axi_arready) begin
            raddr       <= axi_araddr;
            axi_arready <= 1'b0;
            r_state     <= R_READ;
          end else begin
            axi_arready <= 1'b1;
          end
        end
        R_READ: begin
          // The write commit has the port this cycle; retry on the next one,
          // which also guarantees post-write data for a same-word collision.
          if (!commit) begin
            axi_rdata  <= r_hit ? mem[ridx] : '0;
            axi_rresp  <= r_hit ? RESP_OKAY : RESP_SLVERR;
            axi_rvalid <= 1'b1;
            r_state    <= R_RESP;
          end
        end
        R_RESP: begin
          if (axi_rready) begin
            axi_rvalid  <= 1'b0;
            axi_arready <= 1'b1;
            r_state     <= R_IDLE;
          end
        end
        default: begin
          axi_rvalid  <= 1'b0;
          axi_arready <= 1'b0;
          r_state     <= R_IDLE;
        end
      endcase
    end
  end

  // Write channel FSM; AW and W are collected independently, then committed.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state     <= W_IDLE;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) waddr <= axi_awaddr;
          if (w_hs) begin
            wdata_q <= axi_wdata;
            wstrb_q <= axi_wstrb;
          end
          aw_got      <= aw_next;
          w_got       <= w_next;
          axi_awready <= !aw_next;
          axi_wready  <= !w_next;
          if (aw_next && w_next) w_state <= W_COMMIT;
        end
        W_COMMIT: begin
          axi_bresp  <= w_hit ? RESP_OKAY : RESP_SLVERR;
          axi_bvalid <= 1'b1;
          w_state    <= W_RESP;
        end
        W_RESP: begin
          if (axi_bready) begin
            axi_bvalid  <= 1'b0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            axi_awready <= 1'b1;
            axi_wready  <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: begin
          axi_bvalid <= 1'b0;
          aw_got     <= 1'b0;
          w_got      <= 1'b0;
          w_state    <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_dmem.sv
// Self-checking bench for axi_lite_dmem: directed scenarios followed by
// randomized reads/writes compared against a word-array memory model.
module tb_axi_lite_dmem;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [2:0]  axi_arprot;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [2:0]  axi_awprot;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;

  always #5 clk = ~clk;

  axi_lite_dmem dut (
    .clk(clk), .rstn(rstn),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_arprot(axi_arprot), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awprot(axi_awprot), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory: 16 KiB window at address 0, one entry per 32-bit word.
  logic [31:0] ref_mem [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'h0000_4000;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(a / 4) % 4096;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!in_rng(a)) return 32'h0;
    return ref_mem[word_of(a)];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    if (!in_rng(a)) return;
    m = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
    if (!ref_mem.exists(word_of(a))) ref_mem[word_of(a)] = 32'h0;
    ref_mem[word_of(a)] = (ref_mem[word_of(a)] & ~m) | (d & m);
  endtask

  // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
  // lat counts cycles from the handshake-completing cycle (cycle 0) to bvalid.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int skew, input int bp, output logic [1:0] resp, output int lat);
    int cyc, h, aw_st, w_st, to;
    bit aw_done, w_done, hs_aw, hs_w;
    cyc = 0; h = 0; to = 0; aw_done = 0; w_done = 0; lat = -1; resp = 2'b11;
    aw_st = (skew > 0) ? skew : 0;
    w_st  = (skew < 0) ? -skew : 0;
    axi_bready = (bp == 0);
    while (!(aw_done && w_done) && to < 60) begin
      axi_awaddr  = a;
      axi_wdata   = d;
      axi_wstrb   = s;
      axi_awprot  = 3'($urandom);
      axi_awvalid = !aw_done && (cyc >= aw_st);
      axi_wvalid  = !w_done && (cyc >= w_st);
      if (w_done && !aw_done) begin
        check("wready_low_waiting_aw", {31'b0, axi_wready}, 32'd0);
        check("bvalid_low_waiting_aw", {31'b0, axi_bvalid}, 32'd0);
      end
      hs_aw = axi_awvalid && axi_awready;
      hs_w  = axi_wvalid && axi_wready;
      @(posedge clk);
      aw_done = aw_done || hs_aw;
      w_done  = w_done || hs_w;
      if (aw_done && w_done) h = cyc;
      cyc++; to++;
      @(negedge clk);
    end
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      check("write_hs_timeout", {30'b0, aw_done, w_done}, 32'd3);
      return;
    end
    while (!axi_bvalid && to < 60) begin
      @(negedge clk); cyc++; to++;
    end
    if (!axi_bvalid) begin
      check("bvalid_timeout", {31'b0, axi_bvalid}, 32'd1);
      axi_bready = 1'b0;
      return;
    end
    lat  = cyc - h;
    resp = axi_bresp;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bvalid_hold", {31'b0, axi_bvalid}, 32'd1);
      check("bresp_hold", {30'b0, axi_bresp}, {30'b0, resp});
      check("awready_low_in_resp", {31'b0, axi_awready}, 32'd0);
    end
    axi_bready = 1'b1;
    @(negedge clk);
    axi_bready = 1'b0;
    check("bvalid_drop", {31'b0, axi_bvalid}, 32'd0);
    check("awready_back", {31'b0, axi_awready}, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input int bp,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int cyc, h, to;
    bit hs;
    cyc = 0; h = 0; to = 0; hs = 0; lat = -1; data = 32'hx; resp = 2'b11;
    axi_rready = (bp == 0);
    while (!hs && to < 60) begin
      axi_araddr  = a;
      axi_arprot  = 3'($urandom);
      axi_arvalid = 1'b1;
      hs = axi_arready;
      @(posedge clk);
      if (hs) h = cyc;
      cyc++; to++;
      @(negedge clk);
    end
    axi_arvalid = 1'b0;
    if (!hs) begin
      check("ar_hs_timeout", {31'b0, axi_arready}, 32'd1);
      return;
    end
    while (!axi_rvalid && to < 60) begin
      @(negedge clk); cyc++; to++;
    end
    if (!axi_rvalid) begin
      check("rvalid_timeout", {31'b0, axi_rvalid}, 32'd1);
      axi_rready = 1'b0;
      return;
    end
    lat  = cyc - h;
    data = axi_rdata;
    resp = axi_rresp;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("rvalid_hold", {31'b0, axi_rvalid}, 32'd1);
      check("rdata_hold", axi_rdata, data);
      check("rresp_hold", {30'b0, axi_rresp}, {30'b0, resp});
      check("arready_low_in_resp", {31'b0, axi_arready}, 32'd0);
    end
    axi_rready = 1'b1;
    @(negedge clk);
    axi_rready = 1'b0;
    check("rvalid_drop", {31'b0, axi_rvalid}, 32'd0);
    check("arready_back", {31'b0, axi_arready}, 32'd1);
  endtask

  // Write with expectations taken from the model, then update the model.
  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int skew, input int bp);
    logic [1:0] resp;
    int lat;
    do_write(a, d, s, skew, bp, resp, lat);
    check({tag, "_bresp"}, {30'b0, resp}, in_rng(a) ? 32'd0 : 32'd2);
    check({tag, "_blat"}, lat, 32'd2);
    model_write(a, d, s);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input int bp);
    logic [31:0] data;
    logic [1:0]  resp;
    int lat;
    do_read(a, bp, data, resp, lat);
    check({tag, "_rdata"}, data, model_read(a));
    check({tag, "_rresp"}, {30'b0, resp}, in_rng(a) ? 32'd0 : 32'd2);
    check({tag, "_rlat"}, lat, 32'd2);
  endtask

  task automatic check_idle_readies(input string tag);
    check({tag, "_arready"}, {31'b0, axi_arready}, 32'd1);
    check({tag, "_awready"}, {31'b0, axi_awready}, 32'd1);
    check({tag, "_wready"},  {31'b0, axi_wready},  32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    rstn = 1'b0;
    axi_araddr = '0; axi_arvalid = 0; axi_arprot = '0; axi_rready = 0;
    axi_awaddr = '0; axi_awvalid = 0; axi_awprot = '0;
    axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 0; axi_bready = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_arready", {31'b0, axi_arready}, 32'd0);
    check("rst_awready", {31'b0, axi_awready}, 32'd0);
    check("rst_wready",  {31'b0, axi_wready},  32'd0);
    check("rst_rvalid",  {31'b0, axi_rvalid},  32'd0);
    check("rst_bvalid",  {31'b0, axi_bvalid},  32'd0);
    check("rst_rdata",   axi_rdata,            32'd0);
    check("rst_rresp",   {30'b0, axi_rresp},   32'd0);
    check("rst_bresp",   {30'b0, axi_bresp},   32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_readies("post_rst");

    // Store word, AW and W together, then read back
    wr("sw", 32'h10, 32'hDEADBEEF, 4'b1111, 0, 0);
    rd("lw", 32'h10, 0);
    check("lw_literal", model_read(32'h10), 32'hDEADBEEF);

    // Byte strobes
    wr("preset20", 32'h20, 32'h11223344, 4'b1111, 0, 1);
    wr("sb1", 32'h20, 32'h0000AA00, 4'b0010, 0, 0);
    rd("sb1_rd", 32'h20, 0);
    wr("sh2", 32'h22, 32'h55660000, 4'b1100, -1, 0);
    rd("sh2_rd", 32'h21, 1);
    check("sh2_literal", model_read(32'h20), 32'h5566AA44);
    wr("nostrb", 32'h20, 32'hFFFFFFFF, 4'b0000, 0, 0);
    rd("nostrb_rd", 32'h20, 0);

    // Channel skew: W three cycles before AW
    wr("skew_w3", 32'h30, 32'hA5A5_0F0F, 4'b1111, 3, 0);
    rd("skew_w3_rd", 32'h30, 0);
    wr("skew_aw2", 32'h34, 32'h1234_5678, 4'b1111, -2, 0);
    rd("skew_aw2_rd", 32'h34, 0);

    // Backpressure on both response channels
    wr("bp_w", 32'h38, 32'h0BAD_CAFE, 4'b1111, 0, 5);
    rd("bp_r", 32'h38, 5);

    // Out of window: SLVERR, read data zero, RAM[0] untouched
    wr("preset0", 32'h0, 32'hCAFE_F00D, 4'b1111, 0, 0);
    rd("oor_rd", 32'h0001_0000, 2);
    wr("oor_wr", 32'h0001_0000, 32'h1111_2222, 4'b1111, 0, 0);
    rd("oor_ram0", 32'h0, 0);
    check("oor_ram0_literal", model_read(32'h0), 32'hCAFE_F00D);

    // Collision: read enters its RAM-access cycle together with the commit
    wr("preset40", 32'h40, 32'h0101_0101, 4'b1111, 0, 0);
    axi_araddr = 32'h40; axi_awaddr = 32'h40;
    axi_wdata = 32'hBEEF_0002; axi_wstrb = 4'b1111;
    check_idle_readies("coll_pre");
    axi_arvalid = 1; axi_awvalid = 1; axi_wvalid = 1;
    @(negedge clk);
    axi_arvalid = 0; axi_awvalid = 0; axi_wvalid = 0;
    axi_rready = 1; axi_bready = 1;
    model_write(32'h40, 32'hBEEF_0002, 4'b1111);
    check("coll_c1_rvalid", {31'b0, axi_rvalid}, 32'd0);
    check("coll_c1_bvalid", {31'b0, axi_bvalid}, 32'd0);
    @(negedge clk);
    check("coll_c2_bvalid", {31'b0, axi_bvalid}, 32'd1);
    check("coll_c2_rvalid", {31'b0, axi_rvalid}, 32'd0);
    @(negedge clk);
    check("coll_c3_rvalid", {31'b0, axi_rvalid}, 32'd1);
    check("coll_c3_rdata", axi_rdata, model_read(32'h40));
    @(negedge clk);
    axi_rready = 0; axi_bready = 0;
    check("coll_done_rvalid", {31'b0, axi_rvalid}, 32'd0);

    // Reset while in W_RESP: write has landed, response is abandoned
    axi_awaddr = 32'h48; axi_wdata = 32'h7777_8888; axi_wstrb = 4'b1111;
    axi_awvalid = 1; axi_wvalid = 1;
    @(negedge clk);
    axi_awvalid = 0; axi_wvalid = 0;
    @(negedge clk);
    check("rst_wresp_bvalid_pre", {31'b0, axi_bvalid}, 32'd1);
    model_write(32'h48, 32'h7777_8888, 4'b1111);
    rstn = 0;
    @(negedge clk);
    check("rst_wresp_bvalid", {31'b0, axi_bvalid}, 32'd0);
    check("rst_wresp_awready", {31'b0, axi_awready}, 32'd0);
    rstn = 1;
    repeat (2) @(negedge clk);
    check_idle_readies("rst_wresp_after");
    rd("rst_wresp_rd", 32'h48, 0);

    // Reset on the commit edge: write never reaches RAM
    wr("preset4c", 32'h4C, 32'h0000_1111, 4'b1111, 0, 0);
    axi_awaddr = 32'h4C; axi_wdata = 32'hFFFF_FFFF; axi_wstrb = 4'b1111;
    axi_awvalid = 1; axi_wvalid = 1;
    @(negedge clk);
    axi_awvalid = 0; axi_wvalid = 0;
    rstn = 0;
    @(negedge clk);
    check("rst_commit_bvalid", {31'b0, axi_bvalid}, 32'd0);
    rstn = 1;
    repeat (2) @(negedge clk);
    rd("rst_commit_rd", 32'h4C, 0);

    // Randomized traffic over a preset region plus out-of-window accesses
    for (int k = 0; k < 32; k++) wr("rnd_preset", 32'((64 + k) * 4), $urandom, 4'b1111, 0, 0);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_4000;
      else a = 32'((64 + $urandom_range(0, 31)) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        wr("rnd_wr", a, d, s, $urandom_range(0, 6) - 3, $urandom_range(0, 3));
      end else begin
        rd("rnd_rd", a, $urandom_range(0, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_dmem.md
Name: axi_lite_dmem

Overview:
- AXI4-Lite slave data memory; sits directly downstream of the core's MEM stage on its axi_* data bus.
- Serves word-aligned reads and byte-strobed writes from an internal single-port synchronous RAM.
- Out-of-window addresses get SLVERR.
- One outstanding transaction per channel (read, write); the read and write FSMs are independent but share the RAM port.

Parameters:
- WORDS_LOG2, 12, log2 of RAM depth in 32-bit words (default 16 KiB).
- BASE_ADDR, 32'h0000_0000, byte base of window; must be aligned to 4<<WORDS_LOG2.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- axi_araddr  in  32  read address
- axi_arvalid  in  1  read address valid
- axi_arready  out  1  read address ready
- axi_arprot  in  3  ignored
- axi_rdata  out  32  read data
- axi_rresp  out  2  read response (00 OKAY, 10 SLVERR)
- axi_rvalid  out  1  read data valid
- axi_rready  in  1  read data ready
- axi_awaddr  in  32  write address
- axi_awvalid  in  1  write address valid
- axi_awready  out  1  write address ready
- axi_awprot  in  3  ignored
- axi_wdata  in  32  write data
- axi_wstrb  in  4  byte strobes, bit i = byte [8i+7:8i]
- axi_wvalid  in  1  write data valid
- axi_wready  out  1  write data ready
- axi_bresp  out  2  write response (00 OKAY, 10 SLVERR)
- axi_bvalid  out  1  write response valid
- axi_bready  in  1  write response ready

Behaviour:
- Reset: clk rising edge with rstn=0.
  - All outputs go to 0: arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp.
  - Both FSMs go to their idle state; latched-flag registers are cleared.
  - RAM contents are not reset.
  - Reset mid-transaction abandons it with no response; a write not yet committed never reaches RAM.
- All outputs are registered.
- Window check: in_range = (addr[31:WORDS_LOG2+2] == BASE_ADDR[31:WORDS_LOG2+2]). RAM index = addr[WORDS_LOG2+1:2]; addr[1:0] is ignored.
- Read FSM:
  - R_IDLE:
    - arready=1 (from the first cycle after reset release).
    - On arvalid&arready: latch araddr, arready<=0, go to R_READ.
  - R_READ:
    - If the write FSM is in W_COMMIT this cycle, stall (write has port priority).
    - Otherwise: rdata<=RAM[idx] if in_range, else 0; rresp<=in_range?00:10; rvalid<=1; go to R_RESP.
  - R_RESP:
    - Hold rdata, rresp and rvalid stable until rready.
    - On rvalid&rready: rvalid<=0, arready<=1, go to R_IDLE.
  - Latency: rvalid is high 2 cycles after the AR handshake edge, 3 if stalled by a write. rready may already be high.
- Write FSM:
  - W_IDLE:
    - awready=1 while AW is not latched; wready=1 while W is not latched.
    - AW and W may arrive in either order or in the same cycle.
    - Each handshake latches its payload and drops its own ready.
    - When both are latched (including the same edge as the last handshake), go to W_COMMIT.
  - W_COMMIT (one cycle):
    - If in_range, write RAM[idx] byte-wise where wstrb[i]=1. wstrb=0000 writes nothing and returns OKAY.
    - Out-of-range writes nothing.
    - bresp<=in_range?00:10; bvalid<=1; go to W_RESP.
  - W_RESP:
    - Hold bvalid until bready.
    - On handshake: bvalid<=0, clear flags, awready<=1, wready<=1, go to W_IDLE.
- Ordering: a read reaching R_READ in the same cycle as W_COMMIT to the same word returns post-write data.
- No read/write ordering is guaranteed beyond that. The core never overlaps them.
- arprot and awprot have no effect.

Test Plan:
- Reset then write sw: awaddr=0x10, wdata=0xDEADBEEF, wstrb=1111, AW and W in the same cycle -> bvalid 2 cycles later with bresp=00. Then read araddr=0x10 -> rdata=0xDEADBEEF, rresp=00, rvalid 2 cycles after AR.
- Byte strobe: word 0x20 preset to 0x11223344; write wdata=0x0000AA00, wstrb=0010 -> read returns 0x1122AA44. Then wstrb=1100, wdata=0x5566_0000 -> read returns 0x5566AA44.
- Channel skew: W handshaken 3 cycles before AW -> wready low after its handshake, no RAM write until AW arrives, bvalid 2 cycles after the AW handshake.
- Backpressure: hold rready=0 for 5 cycles after rvalid -> rdata, rresp and rvalid stable throughout, arready=0. Same for bvalid with bready=0.
- Out of range (WORDS_LOG2=12, BASE=0): read 0x0001_0000 -> rresp=10, rdata=0. Write 0x0001_0000 -> bresp=10, and RAM[0] is unchanged on readback.
- Collision and reset: read FSM reaches R_READ in the same cycle as W_COMMIT to the same word -> rvalid delayed 1 cycle, new data returned. Assert rstn=0 in W_RESP -> bvalid=0 next cycle and idle readies restored after release.
